// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer.
package rob_pkg;

  localparam int TAG_W = 6;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [TAG_W-1:0] new_tag;
    logic [TAG_W-1:0] old_tag;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Picks up to two in-order retirees from the head of the reorder buffer.
// ROB_DUAL_RETIRE_EN enables the second retirement slot; otherwise it is tied off.
module rob_retire_select
  import rob_pkg::*;
(
  input  rob_entry_t       i_head,
  input  rob_entry_t       i_next,
  output logic             o_r0,
  output logic             o_r1,
  output logic [TAG_W-1:0] o_old_1,
  output logic [TAG_W-1:0] o_old_2
);

  logic w_unused;

  assign o_r0    = i_head.valid & i_head.done;
  assign o_old_1 = o_r0 ? i_head.old_tag : '0;

`ifdef ROB_DUAL_RETIRE_EN
  // The second slot may only retire behind a retiring head, keeping program order.
  assign o_r1     = o_r0 & i_next.valid & i_next.done;
  assign o_old_2  = o_r1 ? i_next.old_tag : '0;
  assign w_unused = ^{i_head.new_tag, i_next.new_tag};
`else
  assign o_r1     = 1'b0;
  assign o_old_2  = '0;
  assign w_unused = ^{i_head.new_tag, i_next};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete by index, retire done entries from head.
// Retirement width is set by ROB_DUAL_RETIRE_EN (two per cycle when defined, one otherwise).
module reorder_buffer #(
  parameter int DEPTH = rob_pkg::DEPTH,
  parameter int TAG_W = rob_pkg::TAG_W,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [TAG_W-1:0] alloc_new_tag,
  input  logic [TAG_W-1:0] alloc_old_tag,
  output logic [IDX_W-1:0] alloc_idx,
  output logic             full,
  output logic             empty,
  input  logic             complete_valid_a,
  input  logic             complete_valid_b,
  input  logic [IDX_W-1:0] complete_idx_a,
  input  logic [IDX_W-1:0] complete_idx_b,
  output logic [TAG_W-1:0] freed_tag_1,
  output logic [TAG_W-1:0] freed_tag_2,
  output logic [1:0]       retire_count,
  output logic             error
);

  import rob_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  rob_entry_t       r_rob [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [TAG_W-1:0] r_freed_1;
  logic [TAG_W-1:0] r_freed_2;
  logic [1:0]       r_retire_count;
  logic             r_error;

  logic             w_full;
  logic             w_alloc_ok;
  logic             w_same_idx;
  logic             w_a_ok;
  logic             w_b_ok;
  logic             w_a_bad;
  logic             w_b_bad;
  logic             w_r0;
  logic             w_r1;
  logic [1:0]       w_retired;
  logic [IDX_W-1:0] w_next_idx;
  logic [TAG_W-1:0] w_old_1;
  logic [TAG_W-1:0] w_old_2;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_alloc_ok = alloc_valid & ~w_full;
  assign w_next_idx = r_head + IDX_W'(1);

  // A doubly-named index is ambiguous, so neither port is allowed to touch it.
  assign w_same_idx = complete_valid_a & complete_valid_b & (complete_idx_a == complete_idx_b);
  assign w_a_ok     = complete_valid_a & r_rob[complete_idx_a].valid
                    & ~r_rob[complete_idx_a].done & ~w_same_idx;
  assign w_b_ok     = complete_valid_b & r_rob[complete_idx_b].valid
                    & ~r_rob[complete_idx_b].done & ~w_same_idx;
  assign w_a_bad    = complete_valid_a & ~w_a_ok;
  assign w_b_bad    = complete_valid_b & ~w_b_ok;

  rob_retire_select u_select (
    .i_head  (r_rob[r_head]),
    .i_next  (r_rob[w_next_idx]),
    .o_r0    (w_r0),
    .o_r1    (w_r1),
    .o_old_1 (w_old_1),
    .o_old_2 (w_old_2)
  );

  assign w_retired = {1'b0, w_r0} + {1'b0, w_r1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_freed_1      <= '0;
      r_freed_2      <= '0;
      r_retire_count <= '0;
      r_error        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rob[i] <= '0;
      end
    end else begin
      if (w_r0) r_rob[r_head]     <= '0;
      if (w_r1) r_rob[w_next_idx] <= '0;
      // Retiring entries are already done, so a legal completion never hits them.
      if (w_a_ok) r_rob[complete_idx_a].done <= 1'b1;
      if (w_b_ok) r_rob[complete_idx_b].done <= 1'b1;
      if (w_alloc_ok) begin
        r_rob[r_tail] <= '{valid: 1'b1, done: 1'b0,
                           new_tag: alloc_new_tag, old_tag: alloc_old_tag};
      end
      r_head         <= r_head + IDX_W'(w_retired);
      r_tail         <= r_tail + IDX_W'(w_alloc_ok);
      r_count        <= r_count + CNT_W'(w_alloc_ok) - CNT_W'(w_retired);
      r_freed_1      <= w_old_1;
      r_freed_2      <= w_old_2;
      r_retire_count <= w_retired;
      r_error        <= r_error | (alloc_valid & w_full) | w_a_bad | w_b_bad;
    end
  end

  assign alloc_idx    = r_tail;
  assign full         = w_full;
  assign empty        = (r_count == '0);
  assign freed_tag_1  = r_freed_1;
  assign freed_tag_2  = r_freed_2;
  assign retire_count = r_retire_count;
  assign error        = r_error;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed tables, hand sequences and a queue-based random model.
// Expectations follow ROB_DUAL_RETIRE_EN when it is defined for the build.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int TAG_W = 6;
  localparam int IDX_W = 4;
`ifdef ROB_DUAL_RETIRE_EN
  localparam int MAXR = 2;
`else
  localparam int MAXR = 1;
`endif
  localparam bit DUAL = (MAXR == 2);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             alloc_valid = 1'b0;
  logic [TAG_W-1:0] alloc_new_tag = '0;
  logic [TAG_W-1:0] alloc_old_tag = '0;
  logic [IDX_W-1:0] alloc_idx;
  logic             full;
  logic             empty;
  logic             complete_valid_a = 1'b0;
  logic             complete_valid_b = 1'b0;
  logic [IDX_W-1:0] complete_idx_a = '0;
  logic [IDX_W-1:0] complete_idx_b = '0;
  logic [TAG_W-1:0] freed_tag_1;
  logic [TAG_W-1:0] freed_tag_2;
  logic [1:0]       retire_count;
  logic             error;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_valid      (alloc_valid),
    .alloc_new_tag    (alloc_new_tag),
    .alloc_old_tag    (alloc_old_tag),
    .alloc_idx        (alloc_idx),
    .full             (full),
    .empty            (empty),
    .complete_valid_a (complete_valid_a),
    .complete_valid_b (complete_valid_b),
    .complete_idx_a   (complete_idx_a),
    .complete_idx_b   (complete_idx_b),
    .freed_tag_1      (freed_tag_1),
    .freed_tag_2      (freed_tag_2),
    .retire_count     (retire_count),
    .error            (error)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: program-order queue ----------------
  typedef struct {
    int               idx;
    logic [TAG_W-1:0] old;
    bit               done;
  } m_ent_t;

  m_ent_t           mq[$];
  int               m_tail;
  bit               m_err;
  logic [TAG_W-1:0] m_f1;
  logic [TAG_W-1:0] m_f2;
  int               m_rc;

  function automatic void m_reset();
    mq.delete();
    m_tail = 0;
    m_err  = 0;
    m_f1   = '0;
    m_f2   = '0;
    m_rc   = 0;
  endfunction

  function automatic int m_find(input int idx);
    foreach (mq[i]) if (mq[i].idx == idx) return i;
    return -1;
  endfunction

  function automatic void m_edge(input bit av, input logic [TAG_W-1:0] ot,
                                 input bit cav, input int cai, input bit cbv, input int cbi);
    int pa, pb, n;
    bit a_ok, b_ok, was_full;
    was_full = (mq.size() == DEPTH);
    pa = cav ? m_find(cai) : -1;
    pb = cbv ? m_find(cbi) : -1;
    a_ok = cav && (pa >= 0) && !mq[pa].done;
    b_ok = cbv && (pb >= 0) && !mq[pb].done;
    if (cav && cbv && cai == cbi) begin
      a_ok = 0;
      b_ok = 0;
    end
    if ((cav && !a_ok) || (cbv && !b_ok) || (av && was_full)) m_err = 1;
    m_f1 = '0;
    m_f2 = '0;
    n = 0;
    while (n < MAXR && mq.size() > 0 && mq[0].done) begin
      if (n == 0) m_f1 = mq[0].old;
      else        m_f2 = mq[0].old;
      void'(mq.pop_front());
      n++;
    end
    m_rc = n;
    if (a_ok) mq[m_find(cai)].done = 1;
    if (b_ok) mq[m_find(cbi)].done = 1;
    if (av && !was_full) begin
      mq.push_back('{idx: m_tail, old: ot, done: 1'b0});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endfunction

  function automatic void m_compare();
    chk("freed_tag_1", freed_tag_1, m_f1);
    chk("freed_tag_2", freed_tag_2, m_f2);
    chk("retire_count", retire_count, m_rc);
    chk("error", error, m_err);
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("alloc_idx", alloc_idx, m_tail);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input bit av, input int nt, input int ot,
                      input bit cav, input int cai, input bit cbv, input int cbi);
    alloc_valid      = av;
    alloc_new_tag    = TAG_W'(nt);
    alloc_old_tag    = TAG_W'(ot);
    complete_valid_a = cav;
    complete_idx_a   = IDX_W'(cai);
    complete_valid_b = cbv;
    complete_idx_b   = IDX_W'(cbi);
    @(posedge clk);
    m_edge(av, TAG_W'(ot), cav, cai, cbv, cbi);
    #1;
    m_compare();
    alloc_valid      = 1'b0;
    complete_valid_a = 1'b0;
    complete_valid_b = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    alloc_valid      = 1'b0;
    complete_valid_a = 1'b0;
    complete_valid_b = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit av; int nt; int ot;
    bit cav; int cai; bit cbv; int cbi;
    int e_f1; int e_f2; int e_rc; bit e_err; bit e_empty;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit av, input int nt, input int ot,
                              input bit cav, input int cai, input bit cbv, input int cbi,
                              input int f1, input int f2, input int rc, input bit err, input bit emp);
    tbl.push_back('{av, nt, ot, cav, cai, cbv, cbi, f1, f2, rc, err, emp});
  endfunction

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      step(tbl[i].av, tbl[i].nt, tbl[i].ot, tbl[i].cav, tbl[i].cai, tbl[i].cbv, tbl[i].cbi);
      chk($sformatf("%s_r%0d_f1", tag, i), freed_tag_1, tbl[i].e_f1);
      chk($sformatf("%s_r%0d_f2", tag, i), freed_tag_2, tbl[i].e_f2);
      chk($sformatf("%s_r%0d_rc", tag, i), retire_count, tbl[i].e_rc);
      chk($sformatf("%s_r%0d_err", tag, i), error, tbl[i].e_err);
      chk($sformatf("%s_r%0d_empty", tag, i), empty, tbl[i].e_empty);
    end
    tbl.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    #1 reset = 1'b0;
    #2;
    chk("rst_f1", freed_tag_1, 0);
    chk("rst_f2", freed_tag_2, 0);
    chk("rst_rc", retire_count, 0);
    chk("rst_err", error, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_alloc_idx", alloc_idx, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // single entry life cycle
    add(1, 32, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_table("single");

    // out-of-order completion, in-order retirement
    do_reset();
    add(1, 33, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 34, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 7, DUAL ? 9 : 0, DUAL ? 2 : 1, 0, DUAL);
    add(0, 0, 0, 0, 0, 0, 0, DUAL ? 0 : 9, 0, DUAL ? 0 : 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // x0 destination frees nothing but still retires
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    run_table("ooo");

    // completion of an empty slot
    do_reset();
    step(0, 0, 0, 1, 9, 0, 0);
    chk("empty_slot_err", error, 1);

    // both ports on one index: neither port marks it done
    do_reset();
    chk("err_cleared", error, 0);
    for (int i = 0; i < 4; i++) step(1, 40 + i, 10 + i, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 1, 3);
    chk("same_idx_err", error, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) idle();
    chk("idx3_still_pending", empty, 0);
    chk("idx3_head", alloc_idx, 4);
    step(0, 0, 0, 1, 3, 0, 0);
    idle();
    chk("idx3_retired_tag", freed_tag_1, 13);
    idle();
    chk("idx3_drained", empty, 1);

    // fill, wrap, and alloc-while-full racing a retirement
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, i, i + 1, 0, 0, 0, 0);
    chk("full_set", full, 1);
    chk("full_wrap_idx", alloc_idx, 0);
    chk("full_no_err", error, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 60, 50, 0, 0, 0, 0);
    chk("full_drop_err", error, 1);
    chk("full_drop_idx", alloc_idx, 0);
    chk("full_retire_f1", freed_tag_1, 1);
    chk("full_retire_rc", retire_count, 1);
    chk("full_after_retire", full, 0);
    step(1, 61, 51, 0, 0, 0, 0);
    chk("refill_idx", alloc_idx, 1);
    chk("refill_full", full, 1);

    // reset with entries in flight
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 20 + i, 20 + i, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 1, 0, 1, 1);
    idle();
    chk("pre_reset_f1", freed_tag_1, 20);
    chk("pre_reset_err", error, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_f1", freed_tag_1, 0);
    chk("mid_rst_f2", freed_tag_2, 0);
    chk("mid_rst_rc", retire_count, 0);
    chk("mid_rst_err", error, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_alloc_idx", alloc_idx, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_rst_f1", freed_tag_1, 0);
      chk("post_rst_rc", retire_count, 0);
    end

    // randomized traffic against the queue model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        int nd[$];
        bit av, cav, cbv;
        int cai, cbi, k;
        nd = {};
        foreach (mq[i]) if (!mq[i].done) nd.push_back(mq[i].idx);
        av  = ($urandom_range(0, 99) < 40 + 15 * r);
        cav = 0; cbv = 0; cai = 0; cbi = 0;
        if (nd.size() > 0 && $urandom_range(0, 99) < 60) begin
          k   = $urandom_range(0, nd.size() - 1);
          cav = 1;
          cai = nd[k];
          nd.delete(k);
        end
        if (nd.size() > 0 && $urandom_range(0, 99) < 60) begin
          k   = $urandom_range(0, nd.size() - 1);
          cbv = 1;
          cbi = nd[k];
        end
        if ($urandom_range(0, 299) == 0) begin
          cav = 1;
          cai = $urandom_range(0, DEPTH - 1);
        end
        step(av, $urandom_range(0, 63), $urandom_range(0, 63), cav, cai, cbv, cbi);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
